// File: rtl/fetch_queue.sv
// fetch_queue: buffered, flow-controlled instruction fetch for the CPU front end.
// Two-word reads go to a dual-port instruction memory with a fixed 1-cycle
// latency. Returned words land in a DEPTH-word circular queue, and the head
// instruction is offered through a valid/ready handshake together with its
// immediate word, its address and its length. A redirect flushes the queue
// and restarts fetch at the target.
// Optional feature macro: FETCHQ_BYPASS_EN. When it is defined and the queue
// is empty, the head instruction is presented straight from the memory return.
// Assumes WIDTH >= 16, because the opcode fields occupy bits 15:11.
module fetch_queue #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr1,
  output logic [WIDTH-1:0] imem_addr2,
  input  logic [WIDTH-1:0] imem_rdata1,
  input  logic [WIDTH-1:0] imem_rdata2,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_n,
  output logic [WIDTH-1:0] out_pc,
  output logic             out_len
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;
  // Issue only when the pre-pop occupancy, counting the in-flight pair,
  // leaves room for another two-word return.
  localparam logic [OW-1:0] ISSUE_LIMIT = OW'(DEPTH - 2);

  // Two-word instructions: bit 11 set, except opcodes 1000/1001 and 11111.
  function automatic logic is_two_word(input logic [WIDTH-1:0] w);
    return w[11] && (w[15:12] != 4'b1000) && (w[15:12] != 4'b1001) &&
           (w[15:11] != 5'b11111);
  endfunction

  // Queue storage and control state
  logic [WIDTH-1:0] queue_mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] head_pc_reg;
  logic [WIDTH-1:0] fetch_pc_reg;
  logic             inflight_reg;

  // Combinational helpers
  logic             ret_live;
  logic             bypass;
  logic             pres_len;
  logic             pop;
  logic [WIDTH-1:0] pres_instr;
  logic [WIDTH-1:0] pres_next;
  logic [WIDTH-1:0] issue_pc;
  logic [1:0]       pop_words;
  logic [1:0]       skip_words;
  logic [OW-1:0]    occupancy;
  logic [AW-1:0]    rd_ptr_p1;
  logic [CW-1:0]    count_next;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW-1:0]    wr_ptr_next;
  logic [AW-1:0]    wr_addr2;
  logic [WIDTH-1:0] head_pc_next;

  // A return is live when a request went out last cycle and no redirect
  // discards it in this cycle.
  assign ret_live  = inflight_reg && !redirect;
  assign rd_ptr_p1 = rd_ptr_reg + 1'b1;

`ifdef FETCHQ_BYPASS_EN
  assign bypass = ret_live && (count_reg == '0);
`else
  assign bypass = 1'b0;
`endif

  // Issue side: the free-slot check uses pre-pop occupancy; a redirect always
  // issues at its target in the same cycle.
  always_comb begin
    occupancy = OW'(count_reg) + (inflight_reg ? OW'(2) : OW'(0));
    if (reset) begin
      issue_pc = RESET_PC;
    end else if (redirect) begin
      issue_pc = redirect_pc;
    end else begin
      issue_pc = fetch_pc_reg;
    end
    imem_req = !reset && (redirect || (occupancy <= ISSUE_LIMIT));
  end

  assign imem_addr1 = issue_pc;
  assign imem_addr2 = issue_pc + WIDTH'(1);

  // Presentation: the head comes from the queue, or from the memory return
  // when bypassing. A two-word head waits until its N word is present.
  always_comb begin
    pres_instr = bypass ? imem_rdata1 : queue_mem[rd_ptr_reg];
    pres_next  = bypass ? imem_rdata2 : queue_mem[rd_ptr_p1];
    pres_len   = is_two_word(pres_instr);
    out_valid  = bypass ||
                 ((count_reg != '0) && (!pres_len || (count_reg >= CW'(2))));
    out_len    = out_valid && pres_len;
    out_instr  = out_valid ? pres_instr : '0;
    out_n      = out_len ? pres_next : '0;
    pop        = out_valid && out_ready;
    pop_words  = !pop ? 2'd0 : (out_len ? 2'd2 : 2'd1);
    // Words consumed directly from the return are never written to the queue.
    skip_words = (bypass && pop) ? pop_words : 2'd0;
  end

  assign out_pc = head_pc_reg;

  // Next-state arithmetic for a combined pop and return in the same cycle.
  always_comb begin
    count_next   = CW'(OW'(count_reg) + (ret_live ? OW'(2) : OW'(0)) -
                       OW'(pop_words));
    rd_ptr_next  = rd_ptr_reg + AW'(pop_words - skip_words);
    wr_ptr_next  = ret_live ? (wr_ptr_reg + AW'(2'd2 - skip_words)) : wr_ptr_reg;
    wr_addr2     = (skip_words == 2'd0) ? (wr_ptr_reg + AW'(1)) : wr_ptr_reg;
    head_pc_next = head_pc_reg + WIDTH'(pop_words);
  end

  // Pointer, occupancy and fetch-address state; a redirect overrides
  // everything except reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      head_pc_reg  <= RESET_PC;
      fetch_pc_reg <= RESET_PC;
      inflight_reg <= 1'b0;
    end else if (redirect) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      head_pc_reg  <= redirect_pc;
      fetch_pc_reg <= redirect_pc + WIDTH'(2);
      inflight_reg <= 1'b1;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      head_pc_reg  <= head_pc_next;
      if (imem_req) begin
        fetch_pc_reg <= fetch_pc_reg + WIDTH'(2);
      end
      inflight_reg <= imem_req;
    end
  end

  // Queue storage: write the returned words, skipping any that were consumed
  // through the bypass path.
  always_ff @(posedge clk) begin
    if (!reset && ret_live) begin
      if (skip_words == 2'd0) begin
        queue_mem[wr_ptr_reg] <= imem_rdata1;
      end
      if (skip_words != 2'd2) begin
        queue_mem[wr_addr2] <= imem_rdata2;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: a 1-cycle instruction memory model, a scoreboard
// of the expected instruction stream derived from memory contents, and
// directed checks of reset values, latency, backpressure, redirects and
// address wrap, followed by a randomised run.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr1, imem_addr2;
  logic [15:0] imem_rdata1 = 16'h0, imem_rdata2 = 16'h0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_instr, out_n, out_pc;
  logic        out_len;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  fetch_queue #(.WIDTH(16), .DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr1(imem_addr1), .imem_addr2(imem_addr2),
    .imem_rdata1(imem_rdata1), .imem_rdata2(imem_rdata2),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_n(out_n), .out_pc(out_pc), .out_len(out_len)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle read latency on both ports.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (imem_req) begin
      imem_rdata1 <= mem[imem_addr1];
      imem_rdata2 <= mem[imem_addr2];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference length decode.
  function automatic logic model_len(input logic [15:0] w);
    if (!w[11]) return 1'b0;
    if (w[15:12] == 4'h8 || w[15:12] == 4'h9) return 1'b0;
    if (w[15:12] == 4'hF) return 1'b0;
    return 1'b1;
  endfunction

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] n;
    logic        len;
  } xfer_t;

  xfer_t       sb[$];
  logic [15:0] model_pc;
  xfer_t       got_x, exp_x;

  task automatic sb_push_one();
    xfer_t e;
    e.pc    = model_pc;
    e.instr = mem[model_pc];
    e.len   = model_len(e.instr);
    e.n     = e.len ? mem[model_pc + 16'd1] : 16'h0000;
    sb.push_back(e);
    model_pc = model_pc + (e.len ? 16'd2 : 16'd1);
  endtask

  task automatic sb_restart(input logic [15:0] pc);
    sb.delete();
    model_pc = pc;
    repeat (16) sb_push_one();
  endtask

  // Monitor: each handshake is compared against the scoreboard head; a
  // redirect or reset restarts the expected stream after that comparison.
  always @(negedge clk) begin
    if (reset) begin
      sb_restart(RESET_PC);
    end else begin
      if (out_valid && out_ready) begin
        got_x.pc    = out_pc;
        got_x.instr = out_instr;
        got_x.n     = out_n;
        got_x.len   = out_len;
        if (sb.size() < 8) repeat (8) sb_push_one();
        exp_x = sb.pop_front();
        check("xfer", 64'(got_x), 64'(exp_x));
        n_xfer++;
        $display("xfer pc=%h instr=%h n=%h len=%0d", out_pc, out_instr, out_n, out_len);
      end
      if (redirect) sb_restart(redirect_pc);
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    redirect = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Counts negedges (first one numbered 'start') until out_valid with out_pc==pc.
  task automatic wait_valid_pc(input logic [15:0] pc, input int start, output int cyc);
    cyc = -1;
    for (int i = start; i < start + 20; i++) begin
      @(negedge clk);
      if (out_valid && out_pc == pc) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int lat;
  int exp_lat;
  logic ok;

  initial begin
`ifdef FETCHQ_BYPASS_EN
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

    // Reset values and NOP stream.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req",   64'(imem_req),   64'(0));
    check("rst_valid", 64'(out_valid),  64'(0));
    check("rst_instr", 64'(out_instr),  64'(0));
    check("rst_n",     64'(out_n),      64'(0));
    check("rst_pc",    64'(out_pc),     64'(RESET_PC));
    check("rst_len",   64'(out_len),    64'(0));
    check("rst_addr1", 64'(imem_addr1), 64'(RESET_PC));
    check("rst_addr2", 64'(imem_addr2), 64'(RESET_PC + 16'd1));
    @(posedge clk); #1 reset = 1'b0;
    wait_valid_pc(16'h0000, 0, lat);
    check("first_valid_lat", 64'(lat), 64'(exp_lat));
    repeat (12) @(posedge clk);

    // JMP I with immediate word.
    mem[0] = 16'h2800; mem[1] = 16'h0040;
    apply_reset();
    @(negedge clk);
    check("req_after_release", 64'(imem_req), 64'(1));
    check("addr_after_release", 64'(imem_addr1), 64'(16'h0000));
    wait_valid_pc(16'h0000, 1, lat);
    check("jmp_lat", 64'(lat), 64'(exp_lat));
    check("jmp_instr", 64'(out_instr), 64'(16'h2800));
    check("jmp_n",     64'(out_n),     64'(16'h0040));
    check("jmp_len",   64'(out_len),   64'(1));
    repeat (8) @(posedge clk);

    // Two-word instruction split across a return boundary.
    mem[0] = 16'h0000; mem[1] = 16'h1800; mem[2] = 16'h0005;
    apply_reset();
    wait_valid_pc(16'h0001, 0, lat);
    check("split_lat", 64'(lat), 64'(3));
    check("split_n",   64'(out_n), 64'(16'h0005));
    check("split_len", 64'(out_len), 64'(1));
    repeat (8) @(posedge clk);

    // Backpressure: distinct one-word instructions, consumer stalled.
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) & 16'h07FF;
    out_ready = 1'b0;
    apply_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("full_req",   64'(imem_req),  64'(0));
    check("full_valid", 64'(out_valid), 64'(1));
    check("full_head",  64'(out_pc),    64'(16'h0000));
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("full_req_prepop", 64'(imem_req), 64'(0));
    repeat (12) @(posedge clk);

    // Redirect while a request is in flight.
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) begin ok = 1'b1; break; end
    end
    check("req_before_redirect", 64'(ok), 64'(1));
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 16'h0100;
    @(negedge clk);
    check("redir_req",   64'(imem_req),   64'(1));
    check("redir_addr1", 64'(imem_addr1), 64'(16'h0100));
    check("redir_addr2", 64'(imem_addr2), 64'(16'h0101));
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("post_redir_addr1", 64'(imem_addr1), 64'(16'h0102));
    repeat (10) @(posedge clk);

    // Redirect to the top of the address space.
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 16'hFFFF;
    @(negedge clk);
    check("wrap_addr1", 64'(imem_addr1), 64'(16'hFFFF));
    check("wrap_addr2", 64'(imem_addr2), 64'(16'h0000));
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("wrap_next_addr1", 64'(imem_addr1), 64'(16'h0001));
    repeat (8) @(posedge clk);

    // Randomised program, ready pattern, redirects and a mid-run reset.
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (i == 200) reset = 1'b1;
      else if (i == 202) reset = 1'b0;
      redirect = !reset && ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom);
    end
    @(posedge clk); #1 redirect = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);

    check("xfers_seen", 64'(n_xfer > 200), 64'(1));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
